// File: rtl/vga_dc_pkg.sv
// Shared types and defaults for the VGA pixel-data fetch engine.
// Optional build macro: VGA_DC_BYTE_MASK_EN (zero unselected byte lanes on capture).
package vga_dc_pkg;

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        BPORCH = 2'd1,
        ACTIVE = 2'd2,
        FPORCH = 2'd3
    } vga_state_t;

    typedef enum logic {
        F_IDLE = 1'b0,
        F_REQ  = 1'b1
    } fetch_state_t;

    localparam int unsigned HACT_START_DEF     = 144;
    localparam int unsigned WORDS_PER_LINE_DEF = 20;
    localparam int unsigned FRAME_WORDS_DEF    = 9600;

    function automatic logic [31:0] lane_mask(input logic [3:0] i_bsel);
        logic [31:0] w_mask;
        for (int i = 0; i < 4; i++) begin
            w_mask[8*i +: 8] = {8{i_bsel[i]}};
        end
        return w_mask;
    endfunction

endpackage

// File: rtl/vga_dc_fetch.sv
// Single-outstanding read handshake toward the SRAM arbiter; the request
// address is latched at issue and held until data_en is seen.
//
// state  | meaning
// F_IDLE | no request outstanding, read low
// F_REQ  | read high, address/lanes held until data_en
module vga_dc_fetch
    import vga_dc_pkg::*;
(
    input  logic        clk,
    input  logic        nrst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic        i_data_en,
    output logic        o_busy,
    output logic        o_capture,
    output logic        o_read,
    output logic [31:0] o_addr,
    output logic [3:0]  o_bsel
);

    fetch_state_t r_state;
    fetch_state_t w_next;
    logic [31:0]  r_addr;

    always_ff @(posedge clk) begin
        if (nrst) begin
            r_state <= F_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (nrst) begin
            r_addr <= '0;
        end else if (r_state == F_IDLE && i_req) begin
            r_addr <= i_addr;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            F_IDLE: if (i_req)     w_next = F_REQ;
            F_REQ:  if (i_data_en) w_next = F_IDLE;
            default:               w_next = F_IDLE;
        endcase
    end

    always_comb begin
        o_read    = 1'b0;
        o_addr    = '0;
        o_bsel    = '0;
        o_busy    = 1'b0;
        o_capture = 1'b0;
        if (r_state == F_REQ) begin
            o_read    = 1'b1;
            o_addr    = r_addr;
            o_bsel    = 4'b1111;
            o_busy    = 1'b1;
            o_capture = i_data_en;
        end
    end

endmodule

// File: rtl/vga_data_controller.sv
// Prefetches one framebuffer word ahead of the beam and presents it to the
// pixel serializer. Optional build macro: VGA_DC_BYTE_MASK_EN.
module vga_data_controller
    import vga_dc_pkg::*;
#(
    parameter int unsigned HACT_START     = HACT_START_DEF,
    parameter int unsigned WORDS_PER_LINE = WORDS_PER_LINE_DEF,
    parameter int unsigned FRAME_WORDS    = FRAME_WORDS_DEF
)(
    input  logic        clk,
    input  logic        nrst,
    input  logic [1:0]  VGA_state,
    input  logic [9:0]  h_count,
    input  logic [31:0] VGA_request_address,
    input  logic [31:0] data_from_SRAM,
    input  logic        data_en,
    input  logic [3:0]  byte_select_in,
    output logic        read,
    output logic [31:0] SRAM_address,
    output logic [3:0]  byte_select_out,
    output logic [31:0] data_to_VGA
);

    localparam int unsigned IDX_W    = $clog2(WORDS_PER_LINE + 1);
    localparam logic [9:0]  HLAST_BP = 10'(HACT_START - 1);
    localparam logic [4:0]  HACT_LO  = 5'(HACT_START);

    vga_state_t       w_state;
    vga_state_t       r_prev_state;
    logic [31:0]      r_line_base;
    logic [IDX_W-1:0] r_word_index;
    logic [31:0]      r_next_word;
    logic             r_next_valid;
    logic [31:0]      r_data_to_vga;
    logic             r_discard;

    logic [4:0]       w_p_lo;
    logic             w_fetch_phase;
    logic             w_req;
    logic             w_leave;
    logic             w_xfer;
    logic             w_busy;
    logic             w_capture;
    logic             w_keep;
    logic [31:0]      w_lb_sum;
    logic [31:0]      w_lb_next;
    logic [31:0]      w_req_addr;
    logic [31:0]      w_cap_data;

    assign w_state = vga_state_t'(VGA_state);

    // Only the low five bits of the active pixel index matter for word boundaries.
    assign w_p_lo        = h_count[4:0] - HACT_LO;
    assign w_fetch_phase = (w_state == BPORCH) || (w_state == ACTIVE);
    assign w_req         = !r_next_valid && (r_word_index < IDX_W'(WORDS_PER_LINE)) && w_fetch_phase;
    assign w_leave       = (r_prev_state == ACTIVE) && (w_state != ACTIVE);
    assign w_xfer        = ((w_state == BPORCH) && (h_count == HLAST_BP)) ||
                           ((w_state == ACTIVE) && (w_p_lo == 5'd31));
    assign w_keep        = w_capture && !r_discard;
    assign w_lb_sum      = r_line_base + 32'(WORDS_PER_LINE);
    assign w_lb_next     = (w_lb_sum >= 32'(FRAME_WORDS)) ? '0 : w_lb_sum;
    assign w_req_addr    = VGA_request_address + r_line_base + 32'(r_word_index);

`ifdef VGA_DC_BYTE_MASK_EN
    assign w_cap_data = data_from_SRAM & lane_mask(byte_select_in);
`else
    logic w_unused_bsel;
    assign w_unused_bsel = ^byte_select_in;
    assign w_cap_data    = data_from_SRAM;
`endif

    vga_dc_fetch u_fetch (
        .clk       (clk),
        .nrst      (nrst),
        .i_req     (w_req),
        .i_addr    (w_req_addr),
        .i_data_en (data_en),
        .o_busy    (w_busy),
        .o_capture (w_capture),
        .o_read    (read),
        .o_addr    (SRAM_address),
        .o_bsel    (byte_select_out)
    );

    always_ff @(posedge clk) begin
        if (nrst) begin
            r_prev_state  <= SYNC;
            r_line_base   <= '0;
            r_word_index  <= '0;
            r_next_word   <= '0;
            r_next_valid  <= 1'b0;
            r_data_to_vga <= '0;
            r_discard     <= 1'b0;
        end else begin
            r_prev_state <= w_state;
            if (w_leave) begin
                r_data_to_vga <= '0;
                r_word_index  <= '0;
                r_next_valid  <= 1'b0;
                r_line_base   <= w_lb_next;
                // A read still in flight belongs to the finished line.
                r_discard     <= w_busy && !data_en;
            end else begin
                if (w_capture) begin
                    r_discard <= 1'b0;
                end
                if (w_keep) begin
                    r_next_word  <= w_cap_data;
                    r_word_index <= r_word_index + IDX_W'(1);
                end
                if (w_xfer) begin
                    r_data_to_vga <= r_next_valid ? r_next_word : '0;
                end
                if (w_keep) begin
                    r_next_valid <= 1'b1;
                end else if (w_xfer) begin
                    r_next_valid <= 1'b0;
                end
            end
        end
    end

    assign data_to_VGA = r_data_to_vga;

endmodule

// File: tb/tb_vga_data_controller.sv
// Line-level bench for vga_data_controller: randomized memory latency/data
// against a per-line scoreboard of expected addresses and displayed words.
module tb_vga_data_controller;

    localparam int HS  = 144;
    localparam int WPL = 20;
    localparam int FW  = 50;

    localparam int M_RAND = 0;
    localparam int M_DIR  = 1;
    localparam int M_UF   = 2;
    localparam int M_MASK = 3;

    logic        clk = 1'b0;
    logic        nrst;
    logic [1:0]  VGA_state;
    logic [9:0]  h_count;
    logic [31:0] base;
    logic [31:0] din;
    logic        de;
    logic [3:0]  bsel_in;
    logic        rd;
    logic [31:0] addr;
    logic [3:0]  bsel_out;
    logic [31:0] dout;

    always #5 clk = ~clk;

    vga_data_controller #(
        .HACT_START     (HS),
        .WORDS_PER_LINE (WPL),
        .FRAME_WORDS    (FW)
    ) dut (
        .clk                 (clk),
        .nrst                (nrst),
        .VGA_state           (VGA_state),
        .h_count             (h_count),
        .VGA_request_address (base),
        .data_from_SRAM      (din),
        .data_en             (de),
        .byte_select_in      (bsel_in),
        .read                (rd),
        .SRAM_address        (addr),
        .byte_select_out     (bsel_out),
        .data_to_VGA         (dout)
    );

    int errors = 0;
    int checks = 0;

    int          lb;
    int          issued;
    int          cur_idx;
    int          lat;
    bit          mem_busy;
    logic        prev_rd;
    logic        prev_de;
    logic [31:0] prev_addr;
    logic [31:0] exp_words [WPL];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] st(input int h);
        if (h < 96)            return 2'd0;
        else if (h < HS)       return 2'd1;
        else if (h < HS + 640) return 2'd2;
        else                   return 2'd3;
    endfunction

    function automatic logic [31:0] cap(input logic [31:0] d, input logic [3:0] b);
        logic [31:0] r;
        r = d;
`ifdef VGA_DC_BYTE_MASK_EN
        for (int i = 0; i < 4; i++) begin
            if (!b[i]) r[8*i +: 8] = 8'h00;
        end
`else
        if (b === 4'bxxxx) r = d;
`endif
        return r;
    endfunction

    task automatic run_line(input int mode, input int lat_fix, input int rst_at);
        int          p;
        logic [31:0] exp;
        for (int h = 0; h < 800; h++) begin
            h_count   = 10'(h);
            VGA_state = st(h);

            if (rd) begin
                check("bsel_on", 32'(bsel_out), 32'hF);
            end else begin
                check("bsel_off", 32'(bsel_out), 32'h0);
                check("addr_off", addr, 32'h0);
            end
            if (prev_rd && !prev_de) begin
                check("hold_rd", 32'(rd), 32'h1);
                check("hold_addr", addr, prev_addr);
            end
            if (h < 96) check("sync_rd", 32'(rd), 32'h0);
            if (rd && !mem_busy) begin
                check("req_addr", addr, base + 32'(lb) + 32'(issued));
                cur_idx  = issued;
                issued++;
                mem_busy = 1'b1;
                lat      = (lat_fix < 0) ? int'($urandom_range(25, 0)) : lat_fix;
            end
            p = h - HS;
            if (st(h) == 2'd2) exp = (mode == M_UF) ? 32'h0 : exp_words[p / 32];
            else               exp = 32'h0;
            check("pix", dout, exp);

            if (rst_at >= 0 && h >= rst_at && rd) begin
                nrst = 1'b1;
                de   = 1'b0;
                @(posedge clk);
                #1;
                check("rst_rd", 32'(rd), 32'h0);
                check("rst_addr", addr, 32'h0);
                check("rst_bsel", 32'(bsel_out), 32'h0);
                check("rst_dout", dout, 32'h0);
                nrst     = 1'b0;
                lb       = 0;
                issued   = 0;
                mem_busy = 1'b0;
                prev_rd  = 1'b0;
                prev_de  = 1'b0;
                return;
            end

            de = 1'b0;
            if (mem_busy) begin
                if (mode == M_DIR)     de = 1'b1;
                else if (mode == M_UF) de = (h >= 790);
                else if (lat == 0)     de = 1'b1;
                else                   lat--;
            end else if (mode == M_DIR) begin
                de = 1'b1;
            end
            if (de) begin
                if (mode == M_MASK) begin
                    din     = 32'h6AAA5556;
                    bsel_in = 4'b0011;
                end else begin
                    if (mode == M_DIR && cur_idx == 0)      din = 32'h0;
                    else if (mode == M_DIR && cur_idx == 1) din = 32'hFFFFFFFF;
                    else                                    din = $urandom;
                    bsel_in = 4'($urandom);
                end
                if (mem_busy) exp_words[cur_idx] = cap(din, bsel_in);
            end

            prev_rd   = rd;
            prev_addr = addr;
            prev_de   = de;
            @(posedge clk);
            #1;
            if (prev_de && mem_busy) mem_busy = 1'b0;
        end
        de = 1'b0;
        if (rst_at >= 0) check("rst_trigger", 32'h0, 32'h1);
        check("reads_per_line", 32'(issued), (mode == M_UF) ? 32'd1 : 32'(WPL));
        lb     = (lb + WPL >= FW) ? 0 : lb + WPL;
        issued = 0;
    endtask

    initial begin
        nrst      = 1'b1;
        VGA_state = 2'd0;
        h_count   = '0;
        de        = 1'b0;
        din       = '0;
        bsel_in   = '0;
        base      = '0;
        lb        = 0;
        issued    = 0;
        cur_idx   = 0;
        lat       = 0;
        mem_busy  = 1'b0;
        prev_rd   = 1'b0;
        prev_de   = 1'b0;
        prev_addr = '0;
        for (int i = 0; i < WPL; i++) exp_words[i] = '0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_rd", 32'(rd), 32'h0);
        check("reset_addr", addr, 32'h0);
        check("reset_bsel", 32'(bsel_out), 32'h0);
        check("reset_dout", dout, 32'h0);
        nrst = 1'b0;

        base = 32'h0;
        run_line(M_DIR, 0, -1);
        run_line(M_RAND, 5, -1);
        run_line(M_UF, 0, -1);
        base = 32'hFFFF_FFF8;
        run_line(M_RAND, -1, -1);
        run_line(M_MASK, 3, -1);
        run_line(M_RAND, 20, 100);
        base = $urandom;
        run_line(M_RAND, -1, -1);
        run_line(M_RAND, -1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
